// File: rtl/calc_exec_seq_if.sv
// calc_exec_seq_if: operand/operator/strobe bundle from the entry FSM into the
// execution sequencer, plus the held result and status flags returned to the
// display path. The master side drives operands and strobes; the slave side is
// the sequencer.
interface calc_exec_seq_if #(
  parameter int WIDTH = 10
);
  logic                 clear;
  logic                 start;
  logic [WIDTH-1:0]     num1;
  logic                 num1_neg;
  logic [WIDTH-1:0]     num2;
  logic                 num2_neg;
  logic [1:0]           oper;
  logic [2*WIDTH-1:0]   result;
  logic                 result_neg;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    output clear, start, num1, num1_neg, num2, num2_neg, oper,
    input  result, result_neg, busy, done, error
  );

  modport slave (
    input  clear, start, num1, num1_neg, num2, num2_neg, oper,
    output result, result_neg, busy, done, error
  );
endinterface

// File: rtl/calc_exec_seq.sv
// calc_exec_seq: execution sequencer for the calculator datapath.
// Sign-magnitude add/sub in one cycle, shift-add multiply and restoring divide
// one bit per cycle (WIDTH cycles each). Result and sign are held until the
// next accepted start, a clear or a reset. Divide-by-zero and unsupported
// operators end in ERR, which raises a sticky error flag.
// Build option: define CALC_DIV_EN to compile in the divider; without it
// oper 11 always ends in ERR.
// ERR spans two cycles (arm, then report) so that error completion lines up
// with add/sub completion: done/error rise two edges after LOAD is entered.
module calc_exec_seq #(
  parameter int WIDTH = 10
) (
  input  logic           clock,
  input  logic           reset,
  calc_exec_seq_if.slave bus
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDSUB,
    S_MUL,
    S_DIV,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    a_q, a_d;          // num1: multiplicand (shifts left) / dividend-quotient
  logic [WIDTH-1:0] b_q, b_d;          // num2: multiplier (shifts right) / divisor
  logic [RW-1:0]    acc_q, acc_d;      // product accumulator
  logic [CW-1:0]    cnt_q, cnt_d;      // iteration counter, also ERR phase
  logic             s1_q, s1_d;        // num1 sign
  logic             s2_q, s2_d;        // effective num2 sign (inverted for sub)
  logic [RW-1:0]    result_q, result_d;
  logic             result_neg_q, result_neg_d;
  logic             error_q, error_d;

  logic [RW-1:0]    mag_a;
  logic [RW-1:0]    mag_b;
  logic [RW-1:0]    as_mag;
  logic             as_neg;
  logic [RW-1:0]    mul_sum;

`ifdef CALC_DIV_EN
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder, always < divisor
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_next;
`endif

  assign mag_a = {{WIDTH{1'b0}}, a_q[WIDTH-1:0]};
  assign mag_b = {{WIDTH{1'b0}}, b_q};

  // Sign-magnitude add: add on equal signs, else larger minus smaller with the larger's sign
  always_comb begin
    as_mag = '0;
    as_neg = 1'b0;
    if (s1_q == s2_q) begin
      as_mag = mag_a + mag_b;
      as_neg = s1_q;
    end else if (mag_a >= mag_b) begin
      as_mag = mag_a - mag_b;
      as_neg = s1_q;
    end else begin
      as_mag = mag_b - mag_a;
      as_neg = s2_q;
    end
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set
  always_comb begin
    mul_sum = acc_q + (b_q[0] ? a_q : '0);
  end

`ifdef CALC_DIV_EN
  // One restoring-divide step: bring down the next dividend bit, trial-subtract the divisor
  always_comb begin
    rem_shift = {rem_q, a_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, b_q};
    quo_next  = {a_q[WIDTH-2:0], ~trial[WIDTH]};
  end
`endif

  // Next-state and datapath update; clear overrides everything at the end
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    result_d     = result_q;
    result_neg_d = result_neg_q;
    error_d      = error_q;
`ifdef CALC_DIV_EN
    rem_d        = rem_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_LOAD;
          error_d      = 1'b0;
          result_d     = '0;
          result_neg_d = 1'b0;
        end
      end

      S_LOAD: begin
        a_d   = {{WIDTH{1'b0}}, bus.num1};
        b_d   = bus.num2;
        s1_d  = bus.num1_neg;
        s2_d  = bus.num2_neg ^ (bus.oper == 2'b01);
        acc_d = '0;
        cnt_d = '0;
`ifdef CALC_DIV_EN
        rem_d = '0;
`endif
        case (bus.oper)
          2'b00, 2'b01: state_d = S_ADDSUB;
          2'b10:        state_d = S_MUL;
          default: begin
`ifdef CALC_DIV_EN
            state_d = (bus.num2 != '0) ? S_DIV : S_ERR;
`else
            state_d = S_ERR;
`endif
          end
        endcase
      end

      S_ADDSUB: begin
        result_d     = as_mag;
        result_neg_d = as_neg & (as_mag != '0);
        state_d      = S_DONE;
      end

      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          result_d     = mul_sum;
          result_neg_d = (s1_q ^ s2_q) & (mul_sum != '0);
          cnt_d        = '0;
          state_d      = S_DONE;
        end
      end

`ifdef CALC_DIV_EN
      S_DIV: begin
        rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        a_d   = {{WIDTH{1'b0}}, quo_next};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          result_d     = {{WIDTH{1'b0}}, quo_next};
          result_neg_d = (s1_q ^ s2_q) & (quo_next != '0);
          cnt_d        = '0;
          state_d      = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        if (cnt_q == '0) begin
          cnt_d        = CW'(1);
          error_d      = 1'b1;
          result_d     = '0;
          result_neg_d = 1'b0;
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.clear) begin
      state_d      = S_IDLE;
      result_d     = '0;
      result_neg_d = 1'b0;
      error_d      = 1'b0;
      cnt_d        = '0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      result_q     <= '0;
      result_neg_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef CALC_DIV_EN
      rem_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      result_q     <= result_d;
      result_neg_q <= result_neg_d;
      error_q      <= error_d;
`ifdef CALC_DIV_EN
      rem_q        <= rem_d;
`endif
    end
  end

  assign bus.result     = result_q;
  assign bus.result_neg = result_neg_q;
  assign bus.error      = error_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_ADDSUB) ||
                          (state_q == S_MUL)  || (state_q == S_DIV);
  assign bus.done       = (state_q == S_DONE) || ((state_q == S_ERR) && (cnt_q != '0));

endmodule

// File: tb/tb_calc_exec_seq.sv
// tb_calc_exec_seq: scoreboard bench for calc_exec_seq. Each operation pushes
// an expected record (computed with plain signed arithmetic) when it is
// launched; the record is popped and compared when done rises.
module tb_calc_exec_seq;
  localparam int WIDTH = 10;
  localparam int RW    = 2 * WIDTH;

  logic clock = 1'b0;
  logic reset = 1'b0;

  calc_exec_seq_if #(.WIDTH(WIDTH)) bus ();

  calc_exec_seq #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          neg;
    logic          err;
    logic [7:0]    lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n1, input bit n1n, input int n2, input bit n2n,
                                 input int op);
    exp_t   e;
    longint v1, v2, r, mag;
    e   = '0;
    r   = 0;
    v1  = n1n ? -longint'(n1) : longint'(n1);
    v2  = n2n ? -longint'(n2) : longint'(n2);
    case (op)
      0: r = v1 + v2;
      1: r = v1 - v2;
      2: r = v1 * v2;
      default: begin
`ifdef CALC_DIV_EN
        if (n2 != 0) r = v1 / v2;
        else         e.err = 1'b1;
`else
        e.err = 1'b1;
`endif
      end
    endcase
    mag   = (r < 0) ? -r : r;
    e.res = e.err ? '0 : mag[RW-1:0];
    e.neg = e.err ? 1'b0 : (r < 0);
    if (op < 2 || e.err) e.lat = 8'd3;
    else                 e.lat = 8'(WIDTH + 2);
    return e;
  endfunction

  // Launch one operation, wait for done, compare against the scoreboard head
  task automatic run_op(input string name, input int n1, input bit n1n, input int n2,
                        input bit n2n, input int op);
    exp_t e;
    int   n;
    @(negedge clock);
    bus.num1     = n1[WIDTH-1:0];
    bus.num1_neg = n1n;
    bus.num2     = n2[WIDTH-1:0];
    bus.num2_neg = n2n;
    bus.oper     = op[1:0];
    bus.start    = 1'b1;
    sb.push_back(model(n1, n1n, n2, n2n, op));
    @(posedge clock); #1;
    bus.start = 1'b0;
    n = 1;
    check_eq({name, ".busy_k"}, 64'(bus.busy), 64'd1);
    while (!bus.done && n < 200) begin
      @(posedge clock); #1;
      n++;
      if (n == 2) begin
        bus.num1     = WIDTH'($urandom);
        bus.num2     = WIDTH'($urandom);
        bus.num1_neg = 1'($urandom);
        bus.num2_neg = 1'($urandom);
        bus.oper     = 2'($urandom);
      end
      bus.start = (n == 4);
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    check_eq({name, ".done_seen"}, 64'(bus.done), 64'd1);
    check_eq({name, ".latency"}, 64'(n), 64'(e.lat));
    check_eq({name, ".result"}, 64'(bus.result), 64'(e.res));
    check_eq({name, ".neg"}, 64'(bus.result_neg), 64'(e.neg));
    check_eq({name, ".error"}, 64'(bus.error), 64'(e.err));
    check_eq({name, ".busy_done"}, 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check_eq({name, ".pulse"}, 64'(bus.done), 64'd0);
    check_eq({name, ".restart_ignored"}, 64'(bus.busy), 64'd0);
    check_eq({name, ".held"}, 64'(bus.result), 64'(e.res));
    check_eq({name, ".err_held"}, 64'(bus.error), 64'(e.err));
    $display("op %s: %0d%s op%0d %0d%s -> %s%0d err=%0d lat=%0d", name, n1, n1n ? "-" : "+",
             op, n2, n2n ? "-" : "+", bus.result_neg ? "-" : "+", bus.result, bus.error, n);
  endtask

  task automatic check_zero_outputs(input string name);
    check_eq({name, ".busy"}, 64'(bus.busy), 64'd0);
    check_eq({name, ".done"}, 64'(bus.done), 64'd0);
    check_eq({name, ".result"}, 64'(bus.result), 64'd0);
    check_eq({name, ".neg"}, 64'(bus.result_neg), 64'd0);
    check_eq({name, ".error"}, 64'(bus.error), 64'd0);
  endtask

  task automatic count_spurious_done(input string name);
    int hits;
    hits = 0;
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(posedge clock); #1;
      if (bus.done) hits++;
    end
    check_eq({name, ".no_done"}, 64'(hits), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear    = 1'b0;
    bus.start    = 1'b0;
    bus.num1     = '0;
    bus.num1_neg = 1'b0;
    bus.num2     = '0;
    bus.num2_neg = 1'b0;
    bus.oper     = 2'b00;
    #1 reset = 1'b1;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero_outputs("post_reset");

    run_op("add_mixed", 123, 1'b0, 456, 1'b1, 0);

    // clear in IDLE wipes the held result
    @(negedge clock);
    bus.clear = 1'b1;
    @(posedge clock); #1;
    bus.clear = 1'b0;
    check_zero_outputs("clear_idle");

    // clear takes priority over a simultaneous start
    @(negedge clock);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check_eq("clear_prio.busy", 64'(bus.busy), 64'd0);

    run_op("mul_negneg", 25, 1'b1, 40, 1'b1, 2);
    run_op("mul_max", 999, 1'b0, 999, 1'b0, 2);
    run_op("div_999_7", 999, 1'b0, 7, 1'b0, 3);
    run_op("div_5n_7", 5, 1'b1, 7, 1'b0, 3);
    run_op("div_by_0", 12, 1'b0, 0, 1'b0, 3);
    run_op("div_10n_3", 10, 1'b1, 3, 1'b0, 3);
    run_op("sub_7_3", 7, 1'b0, 3, 1'b0, 1);
    run_op("add_cancel", 500, 1'b1, 500, 1'b0, 0);
    run_op("sub_cancel", 500, 1'b1, 500, 1'b1, 1);
    run_op("add_maxneg", 999, 1'b1, 999, 1'b1, 0);
    run_op("sub_smaller", 3, 1'b0, 9, 1'b0, 1);
    run_op("mul_zero", 0, 1'b1, 37, 1'b1, 2);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", int'($urandom_range(999)), 1'($urandom), int'($urandom_range(999)),
             1'($urandom), int'($urandom_range(3)));
    end

    // clear during MUL: abort with no done, outputs zero
    @(negedge clock);
    bus.num1 = 10'd25; bus.num1_neg = 1'b0;
    bus.num2 = 10'd40; bus.num2_neg = 1'b0;
    bus.oper = 2'b10;  bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    bus.clear = 1'b1;
    @(posedge clock); #1;
    bus.clear = 1'b0;
    check_zero_outputs("clear_mul");
    count_spurious_done("clear_mul");
    run_op("mul_after_clear", 31, 1'b0, 17, 1'b1, 2);

    // asynchronous reset in the middle of a long operation
    @(negedge clock);
    bus.num1 = 10'd999; bus.num1_neg = 1'b0;
    bus.num2 = 10'd7;   bus.num2_neg = 1'b0;
    bus.oper = 2'b11;   bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    count_spurious_done("async_reset");
    run_op("sub_after_reset", 7, 1'b0, 3, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_exec_seq.md
# calc_exec_seq

Execution sequencer for the calculator datapath. Accepts the two sign-magnitude operands and operator latched by the keypad/entry FSM and, on a single-cycle `start` (the calculate strobe issued on equals), sequences the arithmetic: single-cycle add/sub, iterative shift-add multiply and restoring divide. Produces a held sign-magnitude result plus `done`/`error` status to the display path. Division-by-zero detection lives here and drives the entry FSM's error state.

## Interface
- `WIDTH`, 10, operand magnitude width in bits (10 covers 0..999); result magnitude is 2*WIDTH bits
- `clock` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-high; forces IDLE and all outputs to reset values
- `clear` in 1 synchronous abort/clear; priority over `start`
- `start` in 1 single-cycle calculate request; sampled only in IDLE
- `num1` in WIDTH first operand magnitude
- `num1_neg` in 1 first operand sign (1 = negative)
- `num2` in WIDTH second operand magnitude
- `num2_neg` in 1 second operand sign
- `oper` in 2 00 add, 01 sub, 10 mul, 11 div
- `result` out 2*WIDTH result magnitude, held until next accepted `start`, `clear` or `reset`
- `result_neg` out 1 result sign; never 1 when `result` == 0
- `busy` out 1 high in LOAD, ADDSUB, MUL, DIV
- `done` out 1 one-cycle pulse on completion (normal or error)
- `error` out 1 sticky; set on divide-by-zero or unsupported operator, cleared by accepted `start`, `clear`, `reset`

## Operation
- States: IDLE, LOAD, ADDSUB, MUL, DIV, DONE, ERR.
- IDLE: `start`=1 → LOAD; clears `error`, `result`, `result_neg`.
- LOAD: latch operands/operator into internal registers (inputs ignored afterwards). oper 00/01 → ADDSUB; 10 → MUL; 11 with num2≠0 → DIV; 11 with num2==0 → ERR.
- ADDSUB: sub inverts effective sign of num2. Equal signs: mag = a+b, sign = common sign. Different signs: mag = larger − smaller, sign = sign of larger magnitude; equal magnitudes → 0, positive. → DONE.
- MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles; sign = num1_neg XOR num2_neg. → DONE.
- DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles; quotient truncated toward zero, remainder discarded; sign = XOR. → DONE.
- Zero result forces `result_neg`=0 in every operation.
- DONE: `done`=1, result valid; → IDLE next edge.
- ERR: `done`=1, `error`=1, `result`=0; → IDLE next edge.
- `start` outside IDLE ignored (not queued). `clear` in any state → IDLE next edge, `result`=0, `result_neg`=0, `error`=0, `done`=0, iteration counter reset.
- No overflow possible: 2*WIDTH bits holds max sum and max product.

## Timing
- Reset values: state IDLE, `result`=0, `result_neg`=0, `busy`=0, `done`=0, `error`=0.
- Start sampled at edge k. Add/sub: `done` high in cycle after edge k+2. Mul/div: `done` high after edge k+1+WIDTH. Div-by-zero/unsupported: `done` and `error` high after edge k+2 (via ERR).
- `result`/`result_neg` update on the same edge `done` rises; stable thereafter.
- `busy` high from edge k to the edge entering DONE/ERR.
- `done` never asserted for more than one cycle; back-to-back `start` in DONE cycle ignored, next accepted in IDLE.
- `reset` mid-operation: immediate (asynchronous) return to reset values; no `done`.

## Configuration
- `CALC_DIV_EN` defined: DIV state and divider datapath compiled in; oper 11 behaves as above.
- Not defined: no divider logic; oper 11 always → ERR (`error`=1, `result`=0) regardless of num2.

## Test plan
- WIDTH=10, num1=123 +, num2=456 −, oper=00 → `result`=333, `result_neg`=1, `done` after edge k+2, `busy` low after.
- num1=25 −, num2=40 −, oper=10 → `result`=1000, `result_neg`=0, `done` after edge k+11; num1=999, num2=999 → 998001.
- `CALC_DIV_EN`: 999/7 → 142 positive; 5 −/7 → 0, `result_neg`=0; 12/0 → `error`=1, `result`=0, `done` pulse after edge k+2.
- Without `CALC_DIV_EN`: oper=11, num2=3 → `error`=1, `done` pulse, `result`=0.
- During MUL: second `start` ignored; `clear` at cycle 5 → IDLE next edge, no `done`, outputs 0; new `start` then completes normally.
- `reset` asserted mid-DIV asynchronously → all outputs 0 before next clock edge; following 7−3 (oper 01) → 4 positive.
